mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Multi-cycle multiply/divide unit for the E stage; owns the HI/LO registers.
//   Executes the Start/MDUOP/Time/ReadHILO commands produced by the decode-stage control unit.
//   Busy goes to the hazard unit, which stalls D while (Start_E | Busy) and a MD-type instr is in D.
// PARAMETERS
//   TIME_W   4   width of Time port; max programmable latency 2^TIME_W-1 cycles
// PORTS
//   clk       in   1   clock, all state on rising edge
//   reset     in   1   synchronous, active-high
//   Start     in   1   launch MULT/MULTU/DIV/DIVU this cycle (valid only with those MDUOP)
//   MDUOP     in   4   0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO, others = none
//   Time      in   TIME_W  latency in cycles for the launched op (CU: 5 mult, 10 div)
//   ReadHILO  in   2   0 none,1 read HI,2 read LO,3 none
//   SrcA      in   32  rs operand (forwarded)
//   SrcB      in   32  rt operand (forwarded)
//   Busy      out  1   op in flight; registered
//   HI        out  32  HI register (debug/visibility)
//   LO        out  32  LO register
//   MDUOut    out  32  combinational: HI if ReadHILO=1, LO if 2, else 0
// BEHAVIOUR
//   Reset: HI=0, LO=0, Busy=0, cnt=0, pending HI/LO=0; an in-flight op is discarded.
//   Regs: cnt[TIME_W-1:0], Busy, pendHI, pendLO, pendWr (0 for div-by-zero).
//   FSM IDLE (Busy=0) / RUN (Busy=1):
//    IDLE & Start & MDUOP in{1..4}: compute result from SrcA/SrcB into pend regs;
//      cnt<=max(Time,1); Busy<=1 next cycle -> RUN. HI/LO unchanged.
//    RUN: cnt<=cnt-1 each cycle; when cnt==1: if pendWr, HI<=pendHI, LO<=pendLO;
//      Busy<=0 -> IDLE. Busy is high exactly max(Time,1) cycles; new HI/LO
//      visible in the first cycle Busy is low.
//    Start while Busy: ignored (hazard unit guarantees it does not occur).
//    MTHI/MTLO (MDUOP 5/6) in IDLE: HI<=SrcA / LO<=SrcA next edge, no Busy.
//      MTHI/MTLO while Busy: ignored.
//    Start with MDUOP not 1..4: ignored.
//   Arithmetic: MULT {HI,LO}=$signed(A)*$signed(B) 64b; MULTU unsigned 64b.
//    DIV: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
//    DIVU: unsigned quotient/remainder.
//    B==0 for DIV/DIVU: Busy timing unchanged, HI/LO keep old values (pendWr=0).
//    DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
//   Reading: MDUOut reflects current HI/LO regs; reading during Busy returns old values.
//   Reset asserted mid-op: at that edge Busy=0, HI/LO=0, pend write never occurs.
// TESTING
//   1 reset; MULT A=-3 B=5 Time=5 -> Busy high 5 cycles, then HI=FFFFFFFF LO=FFFFFFF1.
//   2 MULTU A=FFFFFFFF B=2 Time=5 -> HI=00000001 LO=FFFFFFFE; ReadHILO=2 -> MDUOut=FFFFFFFE.
//   3 DIV A=-7 B=2 Time=10 -> Busy 10 cycles, LO=FFFFFFFD HI=FFFFFFFF;
//     DIVU A=7 B=2 -> LO=3 HI=1.
//   4 HI=1 LO=2; DIV B=0 -> Busy 10 cycles, HI=1 LO=2 kept;
//     0x80000000/-1 -> LO=80000000 HI=0.
//   5 MTHI A=12345678 idle -> HI next cycle; MTLO and second Start while Busy -> no effect;
//     Time=0 -> Busy 1 cycle.
//   6 reset at cycle 3 of a 10-cycle DIV -> Busy=0, HI=LO=0 next cycle,
//     no late write afterwards.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at launch
// into pending registers and committed after a programmable latency.
module mult_div_unit #(
  parameter int TIME_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [3:0]        MDUOP,
  input  logic [TIME_W-1:0] Time,
  input  logic [1:0]        ReadHILO,
  input  logic [31:0]       SrcA,
  input  logic [31:0]       SrcB,
  output logic              Busy,
  output logic [31:0]       HI,
  output logic [31:0]       LO,
  output logic [31:0]       MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [TIME_W-1:0] cnt;
  logic [31:0]       pend_hi, pend_lo;
  logic              pend_wr;

  logic is_md, launch, done;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  // sign-magnitude divide keeps quotient truncated toward zero and makes
  // 0x80000000 / -1 fall out as 0x80000000 rem 0 without a special case
  logic        a_neg, b_neg;
  logic [31:0] dvd, dvs, quo, rem;
  logic [63:0] prod_s, prod_u;

  assign is_md  = (MDUOP >= OP_MULT) && (MDUOP <= OP_DIVU);
  assign launch = (state == IDLE) && Start && is_md;
  assign done   = (state == RUN) && (cnt == TIME_W'(1));

  always_comb begin
    prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
    prod_u = {32'b0, SrcA} * {32'b0, SrcB};
    a_neg  = (MDUOP == OP_DIV) && SrcA[31];
    b_neg  = (MDUOP == OP_DIV) && SrcB[31];
    dvd    = a_neg ? (~SrcA + 32'd1) : SrcA;
    dvs    = b_neg ? (~SrcB + 32'd1) : SrcB;
    if (dvs == 32'd0) dvs = 32'd1;
    quo    = dvd / dvs;
    rem    = dvd % dvs;
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (MDUOP)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        res_lo = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
        res_hi = a_neg ? (~rem + 32'd1) : rem;
        res_wr = (SrcB != 32'd0);
      end
      default: res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else if (state == IDLE) begin
      if (launch) begin
        cnt     <= (Time == '0) ? TIME_W'(1) : Time;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
      end else if (MDUOP == OP_MTHI) begin
        HI <= SrcA;
      end else if (MDUOP == OP_MTLO) begin
        LO <= SrcA;
      end
    end else begin
      cnt <= cnt - TIME_W'(1);
      if (done && pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end
  end

  always_comb begin
    Busy = (state == RUN);
    case (ReadHILO)
      2'd1:    MDUOut = HI;
      2'd2:    MDUOut = LO;
      default: MDUOut = 32'd0;
    endcase
  end

endmodule
